register_file_multi_way_nw_multi_port_read: RTL

Latch-based, multi-way standard-cell register file. Generalises the 1-write-port multi-way array to N_WRITE independent write ports, with per-byte write enables, per-entry valid bits cleared by reset or flush, and same-cycle write-to-read forwarding. It is the tag/data store for multi-ported L0/L1 caches and register banks, and sits behind a way-select arbiter.

---
 rtl/register_file_multi_way_nw_multi_port_read.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/register_file_multi_way_nw_multi_port_read.sv
// Multi-way, multi-write-port latch register file with byte enables, per-entry
// valid bits and same-cycle write-to-read forwarding.
module register_file_multi_way_nw_multi_port_read #(
  parameter int NB_WAYS    = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int N_READ     = 2,
  parameter int N_WRITE    = 2
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             Flush,
  input  logic [N_READ-1:0]                                ReadEnable,
  input  logic [N_READ-1:0][ADDR_WIDTH-1:0]                ReadAddr,
  output logic [NB_WAYS-1:0][N_READ-1:0][DATA_WIDTH-1:0]   ReadData,
  output logic [NB_WAYS-1:0][N_READ-1:0]                   ReadValid,
  input  logic [N_WRITE-1:0]                               WriteEnable,
  input  logic [N_WRITE-1:0][NB_WAYS-1:0]                  WriteWay,
  input  logic [N_WRITE-1:0][ADDR_WIDTH-1:0]               WriteAddr,
  input  logic [N_WRITE-1:0][DATA_WIDTH/8-1:0]             WriteBE,
  input  logic [N_WRITE-1:0][DATA_WIDTH-1:0]               WriteData
);

  localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
  localparam int NB_BYTES  = DATA_WIDTH / 8;

  logic [N_WRITE-1:0]                  wr_pend;
  logic [N_WRITE-1:0][NB_WAYS-1:0]     wr_way;
  logic [N_WRITE-1:0][ADDR_WIDTH-1:0]  wr_addr;
  logic [N_WRITE-1:0][NB_BYTES-1:0]    wr_be;
  logic [N_WRITE-1:0][DATA_WIDTH-1:0]  wr_data;
  logic                                wr_any;

  logic [NB_WAYS-1:0][NUM_WORDS-1:0]   valid;
  logic [NB_WAYS-1:0][NUM_WORDS-1:0]   valid_set;
  logic [N_READ-1:0][ADDR_WIDTH-1:0]   raddr;

  logic [7:0] mem [NB_WAYS][NUM_WORDS][NB_BYTES];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pend <= '0;
      wr_way  <= '0;
      wr_addr <= '0;
      wr_be   <= '0;
      wr_data <= '0;
    end else begin
      wr_pend <= WriteEnable;
      for (int p = 0; p < N_WRITE; p++) begin
        if (WriteEnable[p]) begin
          wr_way[p]  <= WriteWay[p];
          wr_addr[p] <= WriteAddr[p];
          wr_be[p]   <= WriteBE[p];
          wr_data[p] <= WriteData[p];
        end
      end
    end
  end

  assign wr_any = |wr_pend;

  // Entries touched this cycle; a concurrent Flush must not clear them.
  always_comb begin
    valid_set = '0;
    for (int p = 0; p < N_WRITE; p++) begin
      for (int w = 0; w < NB_WAYS; w++) begin
        valid_set[w][WriteAddr[p]] = valid_set[w][WriteAddr[p]] |
            (WriteEnable[p] & WriteWay[p][w] & (|WriteBE[p]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (Flush) begin
      valid <= valid_set;
    end else begin
      valid <= valid | valid_set;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raddr <= '0;
    end else begin
      for (int r = 0; r < N_READ; r++) begin
        if (ReadEnable[r]) begin
          raddr[r] <= ReadAddr[r];
        end
      end
    end
  end

  // One transparent-high latch per (way, word, byte); lowest port index wins.
  for (genvar w = 0; w < NB_WAYS; w++) begin : g_way
    for (genvar a = 0; a < NUM_WORDS; a++) begin : g_word
      for (genvar b = 0; b < NB_BYTES; b++) begin : g_byte
        logic       cell_we;
        logic [7:0] cell_din;
        logic [7:0] cell_q;
        logic       hit;

        always_comb begin
          cell_we  = 1'b0;
          cell_din = 8'h00;
          hit      = 1'b0;
          for (int p = N_WRITE - 1; p >= 0; p--) begin
            hit      = wr_pend[p] & wr_way[p][w] & wr_be[p][b] &
                       (wr_addr[p] == ADDR_WIDTH'(a));
            cell_we  = cell_we | hit;
            cell_din = hit ? wr_data[p][8*b +: 8] : cell_din;
          end
        end

        always_latch begin
          if (clk && wr_any && cell_we) begin
            cell_q = cell_din;
          end
        end

        assign mem[w][a][b] = cell_q;
      end
    end
  end

  // Forward sampled writes so the whole cycle shows new data, not only the high phase.
  // The valid flops already include this cycle's writes, so ReadValid needs no bypass.
  always_comb begin
    logic [7:0] rbyte;
    logic       fwd;
    ReadData  = '0;
    ReadValid = '0;
    rbyte     = 8'h00;
    fwd       = 1'b0;
    for (int r = 0; r < N_READ; r++) begin
      for (int w = 0; w < NB_WAYS; w++) begin
        ReadValid[w][r] = valid[w][raddr[r]];
        for (int b = 0; b < NB_BYTES; b++) begin
          rbyte = mem[w][raddr[r]][b];
          for (int p = N_WRITE - 1; p >= 0; p--) begin
            fwd   = wr_pend[p] & wr_way[p][w] & wr_be[p][b] & (wr_addr[p] == raddr[r]);
            rbyte = fwd ? wr_data[p][8*b +: 8] : rbyte;
          end
          ReadData[w][r][8*b +: 8] = rbyte;
        end
      end
    end
  end

endmodule
